// File: rtl/fsm_match_monitor_if.sv
// Match-event handshake bundle: the monitor drives valid/latency, the consumer drives ready.
interface fsm_match_monitor_if #(
   parameter int LAT_W = 8
);
   logic             evt_valid;
   logic             evt_ready;
   logic [LAT_W-1:0] evt_lat;

   modport master (output evt_valid, output evt_lat, input evt_ready);
   modport slave  (input evt_valid, input evt_lat, output evt_ready);
endinterface

// File: rtl/fsm_match_monitor.sv
// Watches the 2-bit detector state, times odd->fin latency, and reports it as a
// valid/ready event alongside saturating match statistics and sticky error flags.
module fsm_match_monitor #(
   parameter int LAT_W   = 8,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           count,
   input  logic                 clr_stats,
   fsm_match_monitor_if.master  evt,
   output logic [CNT_W-1:0]     match_cnt,
   output logic                 tmo_flag,
   output logic                 err_flag
);

   typedef enum logic [1:0] {IDLE, TRK, FIN} state_t;

   localparam logic [LAT_W-1:0] TMO_L = LAT_W'(TIMEOUT);

   state_t           state, state_n;
   logic [1:0]       prev;
   logic [LAT_W-1:0] lat, lat_n, lat_inc;
   logic             valid_q, valid_n;
   logic [LAT_W-1:0] out_lat, out_lat_n;
   logic [CNT_W-1:0] cnt_n;
   logic             tmo_n, err_n;
   logic             illegal, match, tmo_set, load;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         prev      <= 2'b00;
         lat       <= '0;
         valid_q   <= 1'b0;
         out_lat   <= '0;
         match_cnt <= '0;
         tmo_flag  <= 1'b0;
         err_flag  <= 1'b0;
      end else begin
         state     <= state_n;
         prev      <= count;
         lat       <= lat_n;
         valid_q   <= valid_n;
         out_lat   <= out_lat_n;
         match_cnt <= cnt_n;
         tmo_flag  <= tmo_n;
         err_flag  <= err_n;
      end
   end

   always_comb begin
      state_n   = state;
      lat_n     = lat;
      match     = 1'b0;
      tmo_set   = 1'b0;
      lat_inc   = lat + 1'b1;
      illegal   = ((prev == 2'b00) && count[1])         ||
                  ((prev == 2'b01) && (count == 2'b11)) ||
                  ((prev == 2'b10) && (count == 2'b10)) ||
                  ((prev == 2'b11) && (count == 2'b10));

      case (state)
         IDLE: begin
            if (!illegal && prev == 2'b00 && count == 2'b01) begin
               state_n = TRK;
               lat_n   = '0;
            end
         end
         TRK: begin
            if (illegal || count == 2'b00) begin
               state_n = IDLE;
            end else if (prev == 2'b10 && count == 2'b01) begin
               lat_n = '0;
            end else if (prev == 2'b10 && count == 2'b11) begin
               match   = 1'b1;
               state_n = FIN;
            end else if (lat_inc == TMO_L) begin
               tmo_set = 1'b1;
               state_n = IDLE;
            end else begin
               lat_n = lat_inc;
            end
         end
         FIN: begin
            if (illegal || count == 2'b00) begin
               state_n = IDLE;
            end else if (count == 2'b01) begin
               state_n = TRK;
               lat_n   = '0;
            end
         end
         default: state_n = IDLE;
      endcase

      // A new match may replace the held event only when the slot frees on this same edge.
      load      = match && (!valid_q || evt.evt_ready);
      valid_n   = valid_q;
      out_lat_n = out_lat;
      if (load) begin
         valid_n   = 1'b1;
         out_lat_n = lat_inc;
      end else if (valid_q && evt.evt_ready) begin
         valid_n = 1'b0;
      end

      cnt_n = match_cnt;
      if (match && match_cnt != '1) cnt_n = match_cnt + 1'b1;
      tmo_n = tmo_flag | tmo_set;
      err_n = err_flag | illegal;
      if (clr_stats) begin
         cnt_n = '0;
         tmo_n = 1'b0;
         err_n = 1'b0;
      end
   end

   assign evt.evt_valid = valid_q;
   assign evt.evt_lat   = out_lat;

endmodule

// File: tb/tb_fsm_match_monitor.sv
// Bench for fsm_match_monitor: cycle-by-cycle vector table plus a scoreboard of delivered latencies.
module tb_fsm_match_monitor;
   localparam int LAT_W   = 8;
   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 64;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [1:0]       count = 2'b00;
   logic             clr_stats = 1'b0;
   logic [CNT_W-1:0] match_cnt;
   logic             tmo_flag, err_flag;

   int total = 0;
   int bad   = 0;
   int idx   = 0;
   logic [LAT_W-1:0] sbq[$];
   logic [LAT_W-1:0] exp_lat;

   typedef struct {
      logic [1:0]       cnt;
      logic             rdy;
      logic             clr;
      logic             ev;
      logic [LAT_W-1:0] lat;
      int               mc;
      logic             tmo;
      logic             err;
      logic             push;
   } vec_t;

   vec_t tbl[$];

   fsm_match_monitor_if #(.LAT_W(LAT_W)) bus();

   fsm_match_monitor #(.LAT_W(LAT_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .count     (count),
      .clr_stats (clr_stats),
      .evt       (bus),
      .match_cnt (match_cnt),
      .tmo_flag  (tmo_flag),
      .err_flag  (err_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s step=%0d got=%0d want=%0d", nm, n, act, want);
      end
   endtask

   function automatic vec_t V(input logic [1:0] c, input logic r, input logic cl, input logic ev,
                              input int lt, input int mc, input logic tm, input logic er,
                              input logic pu);
      vec_t v;
      v.cnt = c; v.rdy = r; v.clr = cl; v.ev = ev; v.lat = lt[LAT_W-1:0];
      v.mc = mc; v.tmo = tm; v.err = er; v.push = pu;
      return v;
   endfunction

   task automatic step(input vec_t v);
      count         = v.cnt;
      bus.evt_ready = v.rdy;
      clr_stats     = v.clr;
      if (v.push) sbq.push_back(v.lat);
      @(posedge clk);
      #1;
      idx++;
      chk("evt_valid", idx, 32'(bus.evt_valid), 32'(v.ev));
      if (v.ev) chk("evt_lat", idx, 32'(bus.evt_lat), 32'(v.lat));
      chk("match_cnt", idx, 32'(match_cnt), v.mc);
      chk("tmo_flag", idx, 32'(tmo_flag), 32'(v.tmo));
      chk("err_flag", idx, 32'(err_flag), 32'(v.err));
   endtask

   // Handshake decided at the coming rising edge; inputs are already stable here.
   always @(negedge clk) begin
      if (!reset && bus.evt_valid && bus.evt_ready) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL handoff_unexpected got_lat=%0d want=none", bus.evt_lat);
         end else begin
            exp_lat = sbq.pop_front();
            chk("handoff_lat", idx, 32'(bus.evt_lat), 32'(exp_lat));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      // basic match, ready high
      tbl.push_back(V(2'b00,1,0, 0,0, 0,0,0,0));
      tbl.push_back(V(2'b01,1,0, 0,0, 0,0,0,0));
      tbl.push_back(V(2'b10,1,0, 0,0, 0,0,0,0));
      tbl.push_back(V(2'b11,1,0, 1,2, 1,0,0,1));
      tbl.push_back(V(2'b11,1,0, 0,0, 1,0,0,0));
      tbl.push_back(V(2'b00,1,0, 0,0, 1,0,0,0));
      // restart on 10->01
      tbl.push_back(V(2'b01,1,0, 0,0, 1,0,0,0));
      tbl.push_back(V(2'b01,1,0, 0,0, 1,0,0,0));
      tbl.push_back(V(2'b01,1,0, 0,0, 1,0,0,0));
      tbl.push_back(V(2'b10,1,0, 0,0, 1,0,0,0));
      tbl.push_back(V(2'b01,1,0, 0,0, 1,0,0,0));
      tbl.push_back(V(2'b10,1,0, 0,0, 1,0,0,0));
      tbl.push_back(V(2'b11,1,0, 1,2, 2,0,0,1));
      tbl.push_back(V(2'b00,1,0, 0,0, 2,0,0,0));
      // backpressure: held, dropped, then handoff with simultaneous match
      tbl.push_back(V(2'b01,0,0, 0,0, 2,0,0,0));
      tbl.push_back(V(2'b10,0,0, 0,0, 2,0,0,0));
      tbl.push_back(V(2'b11,0,0, 1,2, 3,0,0,1));
      tbl.push_back(V(2'b01,0,0, 1,2, 3,0,0,0));
      tbl.push_back(V(2'b01,0,0, 1,2, 3,0,0,0));
      tbl.push_back(V(2'b10,0,0, 1,2, 3,0,0,0));
      tbl.push_back(V(2'b11,0,0, 1,2, 4,0,0,0));
      tbl.push_back(V(2'b01,0,0, 1,2, 4,0,0,0));
      tbl.push_back(V(2'b01,0,0, 1,2, 4,0,0,0));
      tbl.push_back(V(2'b01,0,0, 1,2, 4,0,0,0));
      tbl.push_back(V(2'b10,0,0, 1,2, 4,0,0,0));
      tbl.push_back(V(2'b11,1,0, 1,4, 5,0,0,1));
      tbl.push_back(V(2'b00,1,0, 0,0, 5,0,0,0));
      tbl.push_back(V(2'b00,1,1, 0,0, 0,0,0,0));
      // illegal 00->11 leaves IDLE; later fin is not reported
      tbl.push_back(V(2'b11,1,0, 0,0, 0,0,1,0));
      tbl.push_back(V(2'b01,1,0, 0,0, 0,0,1,0));
      tbl.push_back(V(2'b10,1,0, 0,0, 0,0,1,0));
      tbl.push_back(V(2'b11,1,0, 0,0, 0,0,1,0));
      tbl.push_back(V(2'b00,1,1, 0,0, 0,0,0,0));
      // illegal 10->10 while tracking
      tbl.push_back(V(2'b01,1,0, 0,0, 0,0,0,0));
      tbl.push_back(V(2'b10,1,0, 0,0, 0,0,0,0));
      tbl.push_back(V(2'b10,1,0, 0,0, 0,0,1,0));
      tbl.push_back(V(2'b11,1,0, 0,0, 0,0,1,0));
      tbl.push_back(V(2'b00,1,1, 0,0, 0,0,0,0));
      // clear wins over same-edge flag set and increment
      tbl.push_back(V(2'b11,1,1, 0,0, 0,0,0,0));
      tbl.push_back(V(2'b00,1,0, 0,0, 0,0,0,0));
      tbl.push_back(V(2'b01,1,0, 0,0, 0,0,0,0));
      tbl.push_back(V(2'b10,1,0, 0,0, 0,0,0,0));
      tbl.push_back(V(2'b11,1,1, 1,2, 0,0,0,1));
      tbl.push_back(V(2'b00,1,0, 0,0, 0,0,0,0));

      bus.evt_ready = 1'b0;
      #12;
      chk("rst_evt_valid", 0, 32'(bus.evt_valid), 0);
      chk("rst_evt_lat", 0, 32'(bus.evt_lat), 0);
      chk("rst_match_cnt", 0, 32'(match_cnt), 0);
      chk("rst_tmo_flag", 0, 32'(tmo_flag), 0);
      chk("rst_err_flag", 0, 32'(err_flag), 0);
      #1 reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

      // timeout: entry edge, 63 held edges, then the 64th trips the flag
      step(V(2'b01,1,0, 0,0, 0,0,0,0));
      for (int k = 1; k < TIMEOUT; k++) step(V(2'b01,1,0, 0,0, 0,0,0,0));
      step(V(2'b01,1,0, 0,0, 0,1,0,0));
      step(V(2'b10,1,0, 0,0, 0,1,0,0));
      step(V(2'b11,1,0, 0,0, 0,1,0,0));
      step(V(2'b00,1,1, 0,0, 0,0,0,0));

      // saturation of the match counter
      for (int i = 0; i < 17; i++) begin
         int lo, hi;
         lo = (i > 15) ? 15 : i;
         hi = (i + 1 > 15) ? 15 : i + 1;
         step(V(2'b01,1,0, 0,0, lo,0,0,0));
         step(V(2'b10,1,0, 0,0, lo,0,0,0));
         step(V(2'b11,1,0, 1,2, hi,0,0,1));
         step(V(2'b00,1,0, 0,0, hi,0,0,0));
      end

      // reset while tracking with an event pending
      step(V(2'b01,0,0, 0,0, 15,0,0,0));
      step(V(2'b10,0,0, 0,0, 15,0,0,0));
      step(V(2'b11,0,0, 1,2, 15,0,0,1));
      step(V(2'b01,0,0, 1,2, 15,0,0,0));
      step(V(2'b10,0,0, 1,2, 15,0,0,0));
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_evt_valid", idx, 32'(bus.evt_valid), 0);
      chk("mid_rst_evt_lat", idx, 32'(bus.evt_lat), 0);
      chk("mid_rst_match_cnt", idx, 32'(match_cnt), 0);
      chk("mid_rst_tmo_flag", idx, 32'(tmo_flag), 0);
      chk("mid_rst_err_flag", idx, 32'(err_flag), 0);
      sbq.delete();
      #3 reset = 1'b0;
      // prev must read 00 after reset, so a direct 01 starts tracking
      step(V(2'b01,1,0, 0,0, 0,0,0,0));
      step(V(2'b10,1,0, 0,0, 0,0,0,0));
      step(V(2'b11,1,0, 1,2, 1,0,0,1));
      step(V(2'b00,1,0, 0,0, 1,0,0,0));

      chk("sb_leftover", idx, 32'(sbq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
